// File: rtl/hazard_ctrl_pkg.sv
// Shared core header: register index width, hazard FSM encodings.
package hazard_ctrl_pkg;
  localparam int REG_W   = 5;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use stall, branch flush,
// dmem wait freeze with timeout, and event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             pc_redirect,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);
  state_t             state, state_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               load_use;
  logic               mem_wait;
  logic               freeze;
  logic               act_br;
  logic               act_lu;

  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    pc_redirect   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    load_use = ex_mem_read && ex_rd != '0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) ||
                (id_use_rs2 && id_rs2 == ex_rd));
    mem_wait = mem_access && !dmem_ready;
    freeze   = mem_wait || state == ERR;
    // exclusive action terms so the decoder below is one-hot
    act_br = mem_branch_taken && !freeze;
    act_lu = load_use && !freeze && !mem_branch_taken;
    unique case (1'b1)
      freeze: begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      act_br: begin
        pc_redirect  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end
      act_lu: begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    unique case (state)
      RUN: begin
        if (mem_wait) begin
          state_d = WAIT;
          timer_d = TIMER_W'(1);
        end
      end
      WAIT: begin
        if (!mem_wait) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer == TIMER_W'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      timer   <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      mem_err <= (state_d == ERR);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act_lu),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act_br),
    .cnt   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze),
    .cnt   (wait_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cases plus random traffic
// against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read;
  logic          mem_branch_taken, mem_access, dmem_ready;
  logic          pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic          pc_redirect, if_id_flush, id_ex_flush, ex_mem_flush;
  logic          mem_wb_bubble, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [8:0]    ctl;

  int checks = 0;
  int errors = 0;

  bit m_err;
  int m_run, m_stall, m_flush, m_wait;

  always #5 clk = ~clk;

  assign ctl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
                pc_redirect, if_id_flush, id_ex_flush,
                ex_mem_flush, mem_wb_bubble};

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .mem_branch_taken (mem_branch_taken),
    .mem_access       (mem_access),
    .dmem_ready       (dmem_ready),
    .pc_hold          (pc_hold),
    .if_id_hold       (if_id_hold),
    .id_ex_hold       (id_ex_hold),
    .ex_mem_hold      (ex_mem_hold),
    .pc_redirect      (pc_redirect),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .mem_wb_bubble    (mem_wb_bubble),
    .mem_err          (mem_err),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .wait_cnt         (wait_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int rs1, input int rs2,
                        input bit u1, input bit u2,
                        input bit ld, input int rd,
                        input bit br, input bit acc,
                        input bit rdy);
    id_rs1           = 5'(rs1);
    id_rs2           = 5'(rs2);
    id_use_rs1       = u1;
    id_use_rs2       = u2;
    ex_mem_read      = ld;
    ex_rd            = 5'(rd);
    mem_branch_taken = br;
    mem_access       = acc;
    dmem_ready       = rdy;
  endtask

  task automatic check_regs();
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall", 32'(stall_cnt), 32'(m_stall));
    check("flush", 32'(flush_cnt), 32'(m_flush));
    check("wait", 32'(wait_cnt), 32'(m_wait));
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // one cycle: called at negedge with inputs already applied
  task automatic tick();
    bit lu, mw, frz, br;
    logic [8:0] e;
    #1;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) ||
          (id_use_rs2 && id_rs2 == ex_rd));
    mw  = mem_access && !dmem_ready;
    frz = mw || m_err;
    br  = mem_branch_taken;
    if (frz)     e = 9'b1111_0000_1;
    else if (br) e = 9'b0000_1111_0;
    else if (lu) e = 9'b1100_0010_0;
    else         e = '0;
    check("ctl", 32'(ctl), 32'(e));
    @(posedge clk);
    #1;
    if (frz)     m_wait  = sat(m_wait);
    else if (br) m_flush = sat(m_flush);
    else if (lu) m_stall = sat(m_stall);
    // error after TMO+1 back-to-back wait cycles
    if (!m_err) begin
      if (mw) begin
        m_run++;
        if (m_run > TMO) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    check_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_err = 0; m_run = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    m_err = 0; m_run = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
    #12;
    check_regs();
    check("rst_ctl", 32'(ctl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    set_in(1, 5, 0, 1, 1, 5, 0, 0, 1);
    tick();
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    set_in(0, 0, 1, 1, 1, 0, 0, 0, 1);
    tick();
    check("rd0_cnt", 32'(stall_cnt), 32'd1);

    do_reset();
    set_in(5, 5, 1, 1, 1, 5, 1, 0, 1);
    tick();
    check("br_flush", 32'(flush_cnt), 32'd1);
    check("br_stall", 32'(stall_cnt), 32'd0);

    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    check("mw_cnt", 32'(wait_cnt), 32'd3);
    check("mw_err", 32'(mem_err), 32'd0);

    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    check("tmo_pre", 32'(mem_err), 32'd0);
    tick();
    check("tmo_err", 32'(mem_err), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
    tick();
    check("tmo_hold", 32'(pc_hold), 32'd1);
    check("tmo_stk", 32'(mem_err), 32'd1);
    do_reset();
    check("tmo_clr", 32'(mem_err), 32'd0);

    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (2) tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1;
    check("bf_redir", 32'(pc_redirect), 32'd1);
    tick();

    do_reset();
    set_in(3, 0, 1, 0, 1, 3, 0, 0, 1);
    repeat (20) tick();
    check("sat", 32'(stall_cnt), 32'(CMAX));
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    do_reset();

    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) < 6));
      tick();
      if (i % 40 == 39) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
